// File: rtl/ub_skew_reader.sv
// ub_skew_reader: read-side sequencer for the unified buffer.
// Issues a run of consecutive row reads, then re-times each row into the
// diagonal wavefront the systolic array consumes (lane k delayed k cycles
// relative to lane 0). Every skew stage carries a valid bit with its data.
module ub_skew_reader #(
   parameter int LANES = 32,
   parameter int DW    = 16,
   parameter int AW    = 12
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         start_i,
   input  logic [AW-1:0]                base_addr_i,
   input  logic [AW:0]                  num_rows_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         ub_rd_o,
   output logic [AW-1:0]                ub_addr_rd_o,
   input  logic [LANES-1:0][DW-1:0]     ub_data_i,
   output logic [LANES-1:0]             feed_valid_o,
   output logic [LANES-1:0][DW-1:0]     feed_data_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [AW:0]   CNT_ONE   = 1;
   localparam logic [AW-1:0] ADDR_ONE  = 1;
   // DRAIN lasts LANES+1 cycles: counting LANES down to 0 inclusive
   localparam logic [AW:0]   DRAIN_LEN = (AW+1)'(LANES);

   state_t      state;
   logic [AW:0] cnt;        // remaining reads in READ, remaining flush cycles in DRAIN
   logic        rd_dly;     // read issued last cycle: ub_data_i is fresh this cycle

   // Sequencer FSM with registered outputs; cnt is shared by READ and DRAIN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         cnt          <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         ub_rd_o      <= 1'b0;
         ub_addr_rd_o <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  busy_o <= 1'b1;
                  if (num_rows_i == '0) begin
                     // empty run: report completion next cycle, issue no read
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     state        <= READ;
                     ub_rd_o      <= 1'b1;
                     ub_addr_rd_o <= base_addr_i;
                     cnt          <= num_rows_i - CNT_ONE;
                  end
               end
            end
            READ: begin
               if (cnt == '0) begin
                  state   <= DRAIN;
                  ub_rd_o <= 1'b0;
                  cnt     <= DRAIN_LEN;
               end else begin
                  cnt          <= cnt - CNT_ONE;
                  // address wraps silently at 2^AW
                  ub_addr_rd_o <= ub_addr_rd_o + ADDR_ONE;
               end
            end
            DRAIN: begin
               if (cnt == '0) begin
                  state  <= DONE;
                  done_o <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   // Track the 1-cycle buffer read latency so held buffer output is never valid
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_dly <= 1'b0;
      end else begin
         rd_dly <= ub_rd_o;
      end
   end

   // Triangular skew: lane gi has gi+1 register stages
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [DW-1:0] sr_data  [gi:0];
         logic          sr_valid [gi:0];

         // Shift this lane's data/valid pair; zeros enter when no fresh row
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int s = 0; s <= gi; s++) begin
                  sr_data[s]  <= '0;
                  sr_valid[s] <= 1'b0;
               end
            end else begin
               sr_valid[0] <= rd_dly;
               sr_data[0]  <= rd_dly ? ub_data_i[gi] : '0;
               for (int s = 1; s <= gi; s++) begin
                  sr_valid[s] <= sr_valid[s-1];
                  sr_data[s]  <= sr_data[s-1];
               end
            end
         end

         assign feed_valid_o[gi] = sr_valid[gi];
         assign feed_data_o[gi]  = sr_data[gi];
      end
   endgenerate

endmodule
